snes_poller: RTL and testbench

Parametrised SNES game-pad poller; the successor to the fixed 1200 kHz divider and single-pad controller reader. It generates the shared latch and clock lines for up to NUM_PADS pads wired in parallel and samples one serial line per pad. It publishes debounced-by-frame, active-high button words with per-frame press edges and ID checking, and hands them to the FSM as `button_data`. One free-running tick divider sets bus timing, and an internal poll timer paces frames.

---
 rtl/snes_pkg.sv | 39 +++
 rtl/snes_poller_tick_gen.sv | 34 +++
 rtl/snes_poller.sv | 199 +++++++++++++++++++
 tb/tb_snes_poller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
`default_nettype none
// ============================================================================
//  snes_pkg
//  Shared types and constants for the SNES game-pad poller.
//  Revision: 1.0
// ============================================================================
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit position of each button inside a pad's 12-bit word.
    typedef enum logic [3:0] {
        BTN_B      = 4'd0,
        BTN_Y      = 4'd1,
        BTN_SELECT = 4'd2,
        BTN_START  = 4'd3,
        BTN_UP     = 4'd4,
        BTN_DOWN   = 4'd5,
        BTN_LEFT   = 4'd6,
        BTN_RIGHT  = 4'd7,
        BTN_A      = 4'd8,
        BTN_X      = 4'd9,
        BTN_L      = 4'd10,
        BTN_R      = 4'd11
    } btn_t;

    localparam int       NUM_BTNS    = 12;
    localparam logic [3:0] SNES_ID_OK = 4'b1111;
    localparam int       LATCH_TICKS = 2;
    localparam int       NUM_BITS    = 16;

endpackage
`default_nettype wire

// File: rtl/snes_poller_tick_gen.sv
`default_nettype none
// ============================================================================
//  tick_gen
//  Free-running divider; tick is high for the last clk of every DIV-clk period.
//  Revision: 1.0
// ============================================================================
module tick_gen #(
    parameter int DIV = 300
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snes_poller.sv
`default_nettype none
// ============================================================================
//  snes_poller
//  Polls up to NUM_PADS parallel SNES pads and publishes active-high buttons.
//  Revision: 1.0
// ============================================================================
module snes_poller
    import snes_pkg::*;
#(
    parameter int TICK_DIV   = 300,
    parameter int POLL_TICKS = 2778,
    parameter int NUM_PADS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         poll_now,
    input  logic [NUM_PADS-1:0]          serial_data,
    output logic                         snes_clk,
    output logic                         data_latch,
    output logic [NUM_BTNS*NUM_PADS-1:0] buttons,
    output logic [NUM_BTNS*NUM_PADS-1:0] pressed,
    output logic                         frame_valid,
    output logic [NUM_PADS-1:0]          id_err,
    output logic                         busy
);

    localparam int PW  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int LCW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
    localparam int BW  = $clog2(NUM_BITS);

    logic                w_tick;
    logic [NUM_PADS-1:0] r_sync1;
    logic [NUM_PADS-1:0] r_sync2;
    logic [PW-1:0]       r_poll;
    logic                r_pending;
    logic                w_wrap;
    logic                w_start;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW-1:0]       r_bit;
    logic [BW-1:0]       w_bit_nxt;
    logic [LCW-1:0]      r_lcnt;
    logic [LCW-1:0]      w_lcnt_nxt;
    logic                w_sample;
    logic                w_done;
    logic                r_snes_clk;
    logic                r_latch;
    logic                r_busy;
    logic                r_fv;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= serial_data;
            r_sync2 <= r_sync1;
        end
    end

    assign w_wrap  = w_tick && (r_poll == PW'(POLL_TICKS - 1));
    assign w_start = w_tick && (r_state == ST_IDLE) && enable && (w_wrap || r_pending);
    assign w_done  = (r_state == ST_DONE);

    // A pending-driven start restarts the poll period from this tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_poll    <= PW'(POLL_TICKS - 1);
            r_pending <= 1'b0;
        end else begin
            if (w_start && r_pending) begin
                r_poll <= '0;
            end else if (w_tick) begin
                r_poll <= w_wrap ? '0 : r_poll + 1'b1;
            end
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (poll_now && enable) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_lcnt_nxt  = r_lcnt;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_LATCH;
                    w_lcnt_nxt  = '0;
                end
            end
            ST_LATCH: begin
                if (w_tick) begin
                    if (r_lcnt == LCW'(LATCH_TICKS - 1)) begin
                        w_state_nxt = ST_CLK_LO;
                        w_bit_nxt   = '0;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            ST_CLK_LO: begin
                if (w_tick) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (w_tick) begin
                    if (r_bit == BW'(NUM_BITS - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_state_nxt = ST_CLK_LO;
                    end
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit      <= '0;
            r_lcnt     <= '0;
            r_snes_clk <= 1'b1;
            r_latch    <= 1'b0;
            r_busy     <= 1'b0;
            r_fv       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit      <= w_bit_nxt;
            r_lcnt     <= w_lcnt_nxt;
            r_snes_clk <= (w_state_nxt != ST_CLK_LO);
            r_latch    <= (w_state_nxt == ST_LATCH);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_fv       <= w_done;
        end
    end

    assign snes_clk    = r_snes_clk;
    assign data_latch  = r_latch;
    assign busy        = r_busy;
    assign frame_valid = r_fv;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_BITS-1:0] r_raw;
        logic [NUM_BTNS-1:0] r_btn;
        logic [NUM_BTNS-1:0] r_prs;
        logic                r_err;
        logic [NUM_BTNS-1:0] w_new;

        assign w_new = ~r_raw[NUM_BTNS-1:0];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_raw <= '0;
                r_btn <= '0;
                r_prs <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_raw[r_bit] <= r_sync2[p];
                end
                r_prs <= '0;
                if (w_done) begin
                    // A bad ID (e.g. unplugged pad reads all zeros) keeps the last good word.
                    if (r_raw[NUM_BITS-1 -: 4] == SNES_ID_OK) begin
                        r_btn <= w_new;
                        r_prs <= w_new & ~r_btn;
                        r_err <= 1'b0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
        end

        assign buttons[NUM_BTNS*p +: NUM_BTNS] = r_btn;
        assign pressed[NUM_BTNS*p +: NUM_BTNS] = r_prs;
        assign id_err[p]                       = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_snes_poller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_snes_poller
//  Directed bench for snes_poller with a behavioural two-pad model.
//  Revision: 1.0
// ============================================================================
module tb_snes_poller;

    localparam int TICK_DIV   = 4;
    localparam int POLL_TICKS = 40;
    localparam int NUM_PADS   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic [1:0]  serial_data;
    logic        snes_clk;
    logic        data_latch;
    logic [23:0] buttons;
    logic [23:0] pressed;
    logic        frame_valid;
    logic [1:0]  id_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] raw0 = 16'hFFFF;
    logic [15:0] raw1 = 16'hFFFF;
    logic        force_en = 1'b0;
    logic [1:0]  force_val = 2'b00;
    int          idx = 0;

    snes_poller #(
        .TICK_DIV   (TICK_DIV),
        .POLL_TICKS (POLL_TICKS),
        .NUM_PADS   (NUM_PADS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .poll_now    (poll_now),
        .serial_data (serial_data),
        .snes_clk    (snes_clk),
        .data_latch  (data_latch),
        .buttons     (buttons),
        .pressed     (pressed),
        .frame_valid (frame_valid),
        .id_err      (id_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad shift register: latch reloads to bit 0, each snes_clk rise advances.
    always @(posedge data_latch or posedge snes_clk) begin
        if (data_latch) idx <= 0;
        else if (idx < 16) idx <= idx + 1;
    end

    assign serial_data[0] = force_en ? force_val[0] : ((idx < 16) ? raw0[idx] : 1'b0);
    assign serial_data[1] = force_en ? force_val[1] : ((idx < 16) ? raw1[idx] : 1'b0);

    task automatic wait_latch_rise(input int budget, output bit ok);
        int n = 0;
        while (data_latch !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        while (data_latch !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        ok = (data_latch === 1'b1);
    endtask

    task automatic wait_fv(input int budget, output bit ok);
        int n = 0;
        @(negedge clk);
        while (frame_valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        ok = (frame_valid === 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 24; i++) begin
            force_val = i[1:0];
            @(negedge clk);
            n_checks++;
            if (snes_clk !== 1'b1) begin n_fail++; $display("FAIL reset_snes_clk: got %b expected 1", snes_clk); end
            n_checks++;
            if (data_latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b expected 0", data_latch); end
            n_checks++;
            if (buttons !== 24'h0) begin n_fail++; $display("FAIL reset_buttons: got %h expected 000000", buttons); end
            n_checks++;
            if (busy !== 1'b0 || frame_valid !== 1'b0 || pressed !== 24'h0 || id_err !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_misc: got busy=%b fv=%b pressed=%h id_err=%b expected all 0",
                         busy, frame_valid, pressed, id_err);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_first_frame();
        bit ok;
        int t_latch, cnt, lo, hi;
        raw0 = 16'hF7FE;
        raw1 = 16'hFFFF;
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_latch_rise(40, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL first_latch_timeout: got no latch expected latch"); end
        t_latch = cyc;
        cnt = 0;
        while (data_latch === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
        n_checks++;
        if (cnt !== 8) begin n_fail++; $display("FAIL latch_width: got %0d expected 8", cnt); end
        for (int k = 0; k < 16; k++) begin
            lo = 0;
            while (snes_clk === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
            n_checks++;
            if (lo !== 4) begin n_fail++; $display("FAIL clk_low_bit%0d: got %0d expected 4", k, lo); end
            if (k < 15) begin
                hi = 0;
                while (snes_clk === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
                n_checks++;
                if (hi !== 4) begin n_fail++; $display("FAIL clk_high_bit%0d: got %0d expected 4", k, hi); end
            end
        end
        wait_fv(200, ok);
        n_checks++;
        if (cyc - t_latch !== 137) begin n_fail++; $display("FAIL fv_latency: got %0d expected 137", cyc - t_latch); end
        n_checks++;
        if (buttons !== 24'h000801) begin n_fail++; $display("FAIL buttons_f1: got %h expected 000801", buttons); end
        n_checks++;
        if (pressed !== 24'h000801) begin n_fail++; $display("FAIL pressed_f1: got %h expected 000801", pressed); end
        n_checks++;
        if (id_err !== 2'b00) begin n_fail++; $display("FAIL id_err_f1: got %b expected 00", id_err); end
        @(negedge clk);
        n_checks++;
        if (pressed !== 24'h0 || frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL pressed_clear: got pressed=%h fv=%b expected 000000/0", pressed, frame_valid);
        end
        wait_latch_rise(200, ok);
        n_checks++;
        if (cyc - t_latch !== 160) begin n_fail++; $display("FAIL poll_period: got %0d expected 160", cyc - t_latch); end
        wait_fv(200, ok);
        n_checks++;
        if (pressed !== 24'h0) begin n_fail++; $display("FAIL pressed_f2: got %h expected 000000", pressed); end
        n_checks++;
        if (buttons !== 24'h000801) begin n_fail++; $display("FAIL buttons_f2: got %h expected 000801", buttons); end
    endtask

    task automatic test_id_err();
        bit ok;
        raw1 = 16'hFFFB;
        wait_fv(400, ok);
        n_checks++;
        if (buttons !== 24'h004801) begin n_fail++; $display("FAIL buttons_sel: got %h expected 004801", buttons); end
        n_checks++;
        if (pressed !== 24'h004000) begin n_fail++; $display("FAIL pressed_sel: got %h expected 004000", pressed); end
        n_checks++;
        if (id_err !== 2'b00) begin n_fail++; $display("FAIL id_err_sel: got %b expected 00", id_err); end
        raw1 = 16'h0000;
        wait_fv(400, ok);
        n_checks++;
        if (id_err !== 2'b10) begin n_fail++; $display("FAIL id_err_bad: got %b expected 10", id_err); end
        n_checks++;
        if (buttons !== 24'h004801) begin n_fail++; $display("FAIL buttons_held: got %h expected 004801", buttons); end
        n_checks++;
        if (pressed !== 24'h0) begin n_fail++; $display("FAIL pressed_bad: got %h expected 000000", pressed); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit prev;
        int falls, n, fv_seen, t_latch;
        raw0 = 16'hFEFF;
        raw1 = 16'hFFFF;
        wait_latch_rise(200, ok);
        falls = 0; n = 0; prev = 1'b1;
        while (falls < 8 && n < 200) begin
            @(negedge clk);
            if (prev === 1'b1 && snes_clk === 1'b0) falls++;
            prev = snes_clk;
            n++;
        end
        n_checks++;
        if (falls !== 8) begin n_fail++; $display("FAIL bit7_reach: got %0d falls expected 8", falls); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (snes_clk !== 1'b1 || data_latch !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got snes_clk=%b latch=%b expected 1/0", snes_clk, data_latch);
        end
        n_checks++;
        if (busy !== 1'b0 || buttons !== 24'h0) begin
            n_fail++; $display("FAIL async_reset_state: got busy=%b buttons=%h expected 0/000000", busy, buttons);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n = 0; fv_seen = 0;
        while (data_latch !== 1'b1 && n < 40) begin
            @(negedge clk);
            if (frame_valid === 1'b1) fv_seen++;
            n++;
        end
        n_checks++;
        if (data_latch !== 1'b1) begin n_fail++; $display("FAIL restart_latch: got %b expected 1", data_latch); end
        n_checks++;
        if (fv_seen !== 0) begin n_fail++; $display("FAIL partial_frame: got %0d pulses expected 0", fv_seen); end
        t_latch = cyc;
        wait_fv(200, ok);
        n_checks++;
        if (cyc - t_latch !== 137) begin n_fail++; $display("FAIL restart_latency: got %0d expected 137", cyc - t_latch); end
        n_checks++;
        if (buttons !== 24'h000100 || pressed !== 24'h000100) begin
            n_fail++; $display("FAIL restart_data: got buttons=%h pressed=%h expected 000100/000100", buttons, pressed);
        end
    endtask

    task automatic test_enable_and_poll_now();
        bit ok;
        int l0, t1, latches;
        wait_latch_rise(200, ok);
        l0 = cyc;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        wait_fv(200, ok);
        n_checks++;
        if (cyc - l0 !== 137) begin n_fail++; $display("FAIL disable_publish: got %0d expected 137", cyc - l0); end
        latches = 0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (data_latch === 1'b1) latches++; end
        n_checks++;
        if (latches !== 0) begin n_fail++; $display("FAIL disabled_latch: got %0d expected 0", latches); end
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        latches = 0;
        for (int i = 0; i < 250; i++) begin @(negedge clk); if (data_latch === 1'b1) latches++; end
        n_checks++;
        if (latches !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL poll_now_disabled: got %0d latch clks busy=%b expected 0/0", latches, busy);
        end
        // Poll count is 10 during clks l0+520 .. l0+523.
        while (cyc < l0 + 520) @(negedge clk);
        enable = 1'b1;
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        wait_latch_rise(20, ok);
        n_checks++;
        if (cyc - l0 !== 524) begin n_fail++; $display("FAIL poll_now_start: got %0d expected 524", cyc - l0); end
        t1 = cyc;
        wait_latch_rise(300, ok);
        n_checks++;
        if (cyc - t1 !== 160) begin n_fail++; $display("FAIL period_restart: got %0d expected 160", cyc - t1); end
    endtask

    initial begin
        force_en = 1'b1;
        test_reset();
        test_first_frame();
        test_id_err();
        test_reset_mid_frame();
        test_enable_and_poll_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
